axi_traffic_responder: RTL and testbench

AXI4 subordinate endpoint that terminates the traffic produced by the team's configurable AXI burst generator. It accepts AW/W/AR bursts, returns B responses and synthetic R data after programmable delays, and counts completed transactions. It sits on the generator's manager port in standalone testbenches and FPGA bring-up, replacing real memory. Write and read paths are independent and each has exactly one outstanding transaction.

---
 rtl/axi_traffic_responder.sv | 256 +++++++++++++++++++++++++
 tb/tb_axi_traffic_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_traffic_responder.sv
// AXI4 subordinate sink: terminates AW/W/AR bursts, answers B and address-pattern R data, counts completions.
// Latency: B valid b_delay+1 cycles after the last W beat; first R beat r_delay+1 cycles after AR, then back-to-back.
// Backpressure: one outstanding write and one read; AW/AR stall until their path is idle, B/R held until ready.

package axi_traffic_responder_pkg;

    localparam int unsigned AXI_ADDR_W = 64;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_ID_W   = 8;
    localparam int unsigned AXI_USER_W = 2;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [AXI_USER_W-1:0] user;
    } axi_ax_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
        logic [AXI_USER_W-1:0]   user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_USER_W-1:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_ax_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_rsp_t;

endpackage

module axi_traffic_responder #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned USER_WIDTH = 2,
    parameter type axi_req_t = axi_traffic_responder_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_traffic_responder_pkg::axi_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  axi_req_t    slv_req_i,
    output axi_rsp_t    slv_rsp_o,
    input  logic [7:0]  b_delay_i,
    input  logic [7:0]  r_delay_i,
    input  logic        err_i,
    output logic [31:0] wr_count_o,
    output logic [31:0] rd_count_o
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    w_state_e              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [7:0]            w_len;
    logic [7:0]            w_beat;
    logic [7:0]            b_cnt;
    logic                  w_err;
    logic                  w_mis;
    logic [31:0]           wr_count;

    r_state_e              r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic                  r_err;
    logic [31:0]           rd_count;

    logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
    logic r_last;

    assign aw_rdy = (w_state == W_IDLE);
    assign w_rdy  = (w_state == W_DATA);
    assign b_vld  = (w_state == W_RESP);
    assign ar_rdy = (r_state == R_IDLE);
    assign r_vld  = (r_state == R_DATA);
    assign r_last = (r_beat == r_len);

    // Write path: a delay of zero skips W_WAIT so B is valid the cycle after the last beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state  <= W_IDLE;
            w_id     <= '0;
            w_len    <= '0;
            w_beat   <= '0;
            b_cnt    <= '0;
            w_err    <= 1'b0;
            w_mis    <= 1'b0;
            wr_count <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (slv_req_i.aw_valid) begin
                        w_id    <= slv_req_i.aw.id;
                        w_len   <= slv_req_i.aw.len;
                        b_cnt   <= b_delay_i;
                        w_err   <= err_i;
                        w_mis   <= 1'b0;
                        w_beat  <= '0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (slv_req_i.w_valid) begin
                        w_beat <= w_beat + 8'd1;
                        // last must coincide exactly with beat index len; any other pairing is a mismatch
                        if ((w_beat == w_len) != slv_req_i.w.last) begin
                            w_mis <= 1'b1;
                        end
                        if (slv_req_i.w.last) begin
                            w_state <= (b_cnt == 8'd0) ? W_RESP : W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    b_cnt <= b_cnt - 8'd1;
                    if (b_cnt == 8'd1) begin
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (slv_req_i.b_ready) begin
                        wr_count <= wr_count + 32'd1;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path: same delay scheme; the beat address doubles as the synthetic data pattern.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= R_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            rd_count <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (slv_req_i.ar_valid) begin
                        r_id    <= slv_req_i.ar.id;
                        r_addr  <= slv_req_i.ar.addr;
                        r_len   <= slv_req_i.ar.len;
                        r_size  <= slv_req_i.ar.size;
                        r_burst <= slv_req_i.ar.burst;
                        r_cnt   <= r_delay_i;
                        r_err   <= err_i;
                        r_beat  <= '0;
                        r_state <= (r_delay_i == 8'd0) ? R_DATA : R_WAIT;
                    end
                end
                R_WAIT: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (slv_req_i.r_ready) begin
                        if (r_last) begin
                            rd_count <= rd_count + 32'd1;
                            r_state  <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            // WRAP is deliberately treated as INCR
                            if (r_burst != BURST_FIXED) begin
                                r_addr <= r_addr + (ADDR_WIDTH'(1) << r_size);
                            end
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        slv_rsp_o          = '0;
        slv_rsp_o.aw_ready = aw_rdy;
        slv_rsp_o.w_ready  = w_rdy;
        slv_rsp_o.b_valid  = b_vld;
        slv_rsp_o.b.id     = w_id;
        slv_rsp_o.b.resp   = (w_err || w_mis) ? RESP_SLVERR : RESP_OKAY;
        slv_rsp_o.b.user   = {USER_WIDTH{1'b0}};
        slv_rsp_o.ar_ready = ar_rdy;
        slv_rsp_o.r_valid  = r_vld;
        slv_rsp_o.r.id     = r_id;
        slv_rsp_o.r.data   = DATA_WIDTH'(r_addr);
        slv_rsp_o.r.resp   = r_err ? RESP_SLVERR : RESP_OKAY;
        slv_rsp_o.r.last   = r_last;
        slv_rsp_o.r.user   = {USER_WIDTH{1'b0}};
    end

    assign wr_count_o = wr_count;
    assign rd_count_o = rd_count;

    // Payload, strobes and most AX attributes are intentionally ignored by this sink.
    logic unused_req;
    assign unused_req = ^slv_req_i;

endmodule

// File: tb/tb_axi_traffic_responder.sv
// Self-checking bench for axi_traffic_responder: vector table plus hand sequences, R/B scoreboard.
module tb_axi_traffic_responder;
    import axi_traffic_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    axi_req_t    req;
    axi_rsp_t    rsp;
    logic [7:0]  b_delay;
    logic [7:0]  r_delay;
    logic        err_in;
    logic [31:0] wr_count;
    logic [31:0] rd_count;

    always #5 clk = ~clk;

    axi_traffic_responder dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (req),
        .slv_rsp_o  (rsp),
        .b_delay_i  (b_delay),
        .r_delay_i  (r_delay),
        .err_i      (err_in),
        .wr_count_o (wr_count),
        .rd_count_o (rd_count)
    );

    typedef struct { logic [7:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct {
        bit rd; logic [7:0] id; logic [63:0] addr; int len; logic [2:0] size; logic [1:0] burst;
        logic [7:0] dly; logic e; int nb; int last_idx; logic [1:0] resp; int lat;
    } vec_t;

    r_exp_t r_q[$];
    b_exp_t b_q[$];
    r_exp_t re;
    b_exp_t be;
    vec_t   vecs[7];
    int     tests = 0;
    int     fails = 0;
    int     exp_wr = 0;
    int     exp_rd = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every R/B handshake must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp.r_valid && req.r_ready) begin
                chk("r_expected", 64'(r_q.size() != 0), 64'd1);
                if (r_q.size() != 0) begin
                    re = r_q.pop_front();
                    chk("r_data", rsp.r.data, re.data);
                    chk("r_id", 64'(rsp.r.id), 64'(re.id));
                    chk("r_resp", 64'(rsp.r.resp), 64'(re.resp));
                    chk("r_last", 64'(rsp.r.last), 64'(re.last));
                end
            end
            if (rsp.b_valid && req.b_ready) begin
                chk("b_expected", 64'(b_q.size() != 0), 64'd1);
                if (b_q.size() != 0) begin
                    be = b_q.pop_front();
                    chk("b_id", 64'(rsp.b.id), 64'(be.id));
                    chk("b_resp", 64'(rsp.b.resp), 64'(be.resp));
                end
            end
        end
    end

    task automatic do_aw(input logic [7:0] id, input int len, input logic [7:0] dly, input logic e);
        int n = 0;
        req.aw.id = id; req.aw.len = 8'(len); req.aw.size = 3'd3; req.aw.burst = 2'b01;
        req.aw_valid = 1'b1; b_delay = dly; err_in = e;
        while (!rsp.aw_ready && n < 100) begin tick(); n++; end
        chk("aw_ready", 64'(rsp.aw_ready), 64'd1);
        tick();
        req.aw_valid = 1'b0; b_delay = 8'hff; err_in = 1'b0;
    endtask

    task automatic do_w(input int nb, input int last_idx);
        for (int i = 0; i < nb; i++) begin
            int n = 0;
            req.w_valid = 1'b1; req.w.last = (i == last_idx); req.w.data = {$urandom, $urandom};
            while (!rsp.w_ready && n < 100) begin tick(); n++; end
            chk("w_ready", 64'(rsp.w_ready), 64'd1);
            tick();
        end
        req.w_valid = 1'b0; req.w.last = 1'b0;
    endtask

    task automatic do_ar(input logic [7:0] id, input logic [63:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [7:0] dly,
                         input logic e);
        int n = 0;
        req.ar.id = id; req.ar.addr = addr; req.ar.len = 8'(len); req.ar.size = size;
        req.ar.burst = burst; req.ar_valid = 1'b1; r_delay = dly; err_in = e;
        while (!rsp.ar_ready && n < 100) begin tick(); n++; end
        chk("ar_ready", 64'(rsp.ar_ready), 64'd1);
        tick();
        req.ar_valid = 1'b0; r_delay = 8'hff; err_in = 1'b0;
    endtask

    task automatic push_read(input logic [7:0] id, input logic [63:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
        for (int i = 0; i <= len; i++) begin
            logic [63:0] a;
            a = (burst == 2'b00) ? addr : addr + (64'(i) << size);
            r_q.push_back('{id, a, resp, (i == len)});
        end
    endtask

    task automatic wait_b(output int n);
        n = 0;
        while (!rsp.b_valid && n < 400) begin tick(); n++; end
    endtask

    task automatic wait_r(output int n);
        n = 0;
        while (!rsp.r_valid && n < 400) begin tick(); n++; end
    endtask

    task automatic drain_r();
        int n = 0;
        while (r_q.size() != 0 && n < 400) begin tick(); n++; end
        chk("r_drained", 64'(r_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        //            rd  id     addr                    len sz    burst  dly   e     nb last resp   lat
        vecs[0] = '{1'b0, 8'd5,  64'h0,                  3, 3'd3, 2'b01, 8'd0, 1'b0, 4, 3, 2'b00, 0};
        vecs[1] = '{1'b1, 8'd2,  64'h1000,               3, 3'd3, 2'b01, 8'd4, 1'b0, 0, 0, 2'b00, 4};
        vecs[2] = '{1'b0, 8'd7,  64'h0,                  0, 3'd3, 2'b01, 8'd3, 1'b1, 1, 0, 2'b10, 3};
        vecs[3] = '{1'b0, 8'd9,  64'h0,                  2, 3'd3, 2'b01, 8'd1, 1'b0, 4, 3, 2'b10, 1};
        vecs[4] = '{1'b1, 8'd3,  64'hFFFF_FFFF_FFFF_FFF8, 2, 3'd3, 2'b01, 8'd0, 1'b1, 0, 0, 2'b10, 0};
        vecs[5] = '{1'b1, 8'd1,  64'h20,                 1, 3'd2, 2'b10, 8'd1, 1'b0, 0, 0, 2'b00, 1};
        vecs[6] = '{1'b1, 8'd4,  64'h7,                  2, 3'd0, 2'b01, 8'd0, 1'b0, 0, 0, 2'b00, 0};

        req = '0; b_delay = 8'hff; r_delay = 8'hff; err_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state, and W beats before any AW must stall
        req.w_valid = 1'b1;
        tick(); tick();
        chk("rst_aw_ready", 64'(rsp.aw_ready), 64'd1);
        chk("rst_ar_ready", 64'(rsp.ar_ready), 64'd1);
        chk("rst_w_ready_stall", 64'(rsp.w_ready), 64'd0);
        chk("rst_b_valid", 64'(rsp.b_valid), 64'd0);
        chk("rst_r_valid", 64'(rsp.r_valid), 64'd0);
        chk("rst_wr_count", 64'(wr_count), 64'd0);
        chk("rst_rd_count", 64'(rd_count), 64'd0);
        req.w_valid = 1'b0;
        req.b_ready = 1'b1; req.r_ready = 1'b1;

        for (int v = 0; v < 7; v++) begin
            if (!vecs[v].rd) begin
                b_q.push_back('{vecs[v].id, vecs[v].resp});
                do_aw(vecs[v].id, vecs[v].len, vecs[v].dly, vecs[v].e);
                do_w(vecs[v].nb, vecs[v].last_idx);
                wait_b(n);
                chk($sformatf("v%0d_b_latency", v), 64'(n), 64'(vecs[v].lat));
                tick();
                exp_wr++;
                chk($sformatf("v%0d_wr_count", v), 64'(wr_count), 64'(exp_wr));
            end else begin
                push_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].resp);
                do_ar(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].dly, vecs[v].e);
                wait_r(n);
                chk($sformatf("v%0d_r_latency", v), 64'(n), 64'(vecs[v].lat));
                drain_r();
                exp_rd++;
                chk($sformatf("v%0d_rd_count", v), 64'(rd_count), 64'(exp_rd));
            end
        end

        // Early last (len=1, last on beat 0) with B backpressured for 10 cycles
        req.b_ready = 1'b0;
        b_q.push_back('{8'h11, 2'b10});
        do_aw(8'h11, 1, 8'd0, 1'b0);
        do_w(1, 0);
        wait_b(n);
        chk("err_b_latency", 64'(n), 64'd0);
        for (int i = 0; i < 10; i++) begin
            chk("b_hold", {53'd0, rsp.b_valid, rsp.b.id, rsp.b.resp}, {53'd0, 1'b1, 8'h11, 2'b10});
            tick();
        end
        chk("b_hold_wr_count", 64'(wr_count), 64'(exp_wr));
        req.b_ready = 1'b1;
        tick();
        exp_wr++;
        chk("err_wr_count", 64'(wr_count), 64'(exp_wr));

        // FIXED read with r_ready toggling every cycle
        req.r_ready = 1'b0;
        push_read(8'h0a, 64'h40, 7, 3'd3, 2'b00, 2'b00);
        do_ar(8'h0a, 64'h40, 7, 3'd3, 2'b00, 8'd0, 1'b0);
        n = 0;
        while (r_q.size() != 0 && n < 200) begin req.r_ready = ~req.r_ready; tick(); n++; end
        chk("bp_all_beats", 64'(r_q.size()), 64'd0);
        chk("bp_r_valid_done", 64'(rsp.r_valid), 64'd0);
        exp_rd++;
        chk("bp_rd_count", 64'(rd_count), 64'(exp_rd));
        req.r_ready = 1'b1;

        // Concurrent write and read with err, both completing on the same edge
        req.b_ready = 1'b0; req.r_ready = 1'b0;
        b_q.push_back('{8'h04, 2'b10});
        r_q.push_back('{8'h06, 64'h80, 2'b10, 1'b1});
        req.aw.id = 8'h04; req.aw.len = 8'd0; req.aw_valid = 1'b1;
        req.ar.id = 8'h06; req.ar.addr = 64'h80; req.ar.len = 8'd0; req.ar.size = 3'd3;
        req.ar.burst = 2'b01; req.ar_valid = 1'b1;
        b_delay = 8'd2; r_delay = 8'd2; err_in = 1'b1;
        chk("conc_readies", {62'd0, rsp.aw_ready, rsp.ar_ready}, 64'd3);
        tick();
        req.aw_valid = 1'b0; req.ar_valid = 1'b0; err_in = 1'b0; b_delay = 8'hff; r_delay = 8'hff;
        do_w(1, 0);
        n = 0;
        while (!(rsp.b_valid && rsp.r_valid) && n < 50) begin tick(); n++; end
        chk("conc_valids", {62'd0, rsp.b_valid, rsp.r_valid}, 64'd3);
        chk("conc_wr_before", 64'(wr_count), 64'(exp_wr));
        chk("conc_rd_before", 64'(rd_count), 64'(exp_rd));
        req.b_ready = 1'b1; req.r_ready = 1'b1;
        tick();
        exp_wr++; exp_rd++;
        chk("conc_wr_count", 64'(wr_count), 64'(exp_wr));
        chk("conc_rd_count", 64'(rd_count), 64'(exp_rd));

        // Reset on beat 2 of a 4-beat write with a read stalled mid-burst
        req.r_ready = 1'b0;
        do_ar(8'h0c, 64'h100, 3, 3'd3, 2'b01, 8'd0, 1'b0);
        do_aw(8'h0d, 3, 8'd0, 1'b0);
        do_w(2, 3);
        req.w_valid = 1'b1;
        rst_n = 1'b0;
        tick(); tick();
        req.w_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        exp_wr = 0; exp_rd = 0;
        chk("mid_rst_aw_ready", 64'(rsp.aw_ready), 64'd1);
        chk("mid_rst_ar_ready", 64'(rsp.ar_ready), 64'd1);
        chk("mid_rst_valids", {62'd0, rsp.b_valid, rsp.r_valid}, 64'd0);
        chk("mid_rst_wr_count", 64'(wr_count), 64'd0);
        chk("mid_rst_rd_count", 64'(rd_count), 64'd0);
        req.r_ready = 1'b1;

        b_q.push_back('{8'h0e, 2'b00});
        do_aw(8'h0e, 1, 8'd1, 1'b0);
        do_w(2, 1);
        wait_b(n);
        chk("post_rst_b_latency", 64'(n), 64'd1);
        tick();
        exp_wr++;
        chk("post_rst_wr_count", 64'(wr_count), 64'(exp_wr));
        push_read(8'h0f, 64'h200, 1, 3'd3, 2'b01, 2'b00);
        do_ar(8'h0f, 64'h200, 1, 3'd3, 2'b01, 8'd0, 1'b0);
        drain_r();
        exp_rd++;
        chk("post_rst_rd_count", 64'(rd_count), 64'(exp_rd));
        chk("b_queue_empty", 64'(b_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
